// File: rtl/sync_evt_pkg.sv
// Shared types and sizing helpers for the synchronized edge event queue.
// SYNC_EVT_TIMESTAMP_EN adds a timestamp field to every queued event.
package sync_evt_pkg;

    localparam int EVT_TS_W = 16;

    typedef struct packed {
`ifdef SYNC_EVT_TIMESTAMP_EN
        logic [EVT_TS_W-1:0] ts;
`endif
        logic                rise;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int entry_w(input int ts_w);
`ifdef SYNC_EVT_TIMESTAMP_EN
        return ts_w + 1;
`else
        return (ts_w > 0) ? 1 : 1;
`endif
    endfunction

endpackage

// File: rtl/sync_evt_fifo.sv
// First-word fall-through event FIFO; a push while full is taken
// only when the head is popped in the same cycle.
module sync_evt_fifo
    import sync_evt_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          do_pop;
    logic          do_push;

    assign empty   = (occ == '0);
    assign full    = (occ == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                do_push && !do_pop: occ <= occ + 1'b1;
                do_pop && !do_push: occ <= occ - 1'b1;
                default:            occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sync_edge_event_queue.sv
// Glitch filter plus edge-event queue behind a CDC synchronizer.
// SYNC_EVT_TIMESTAMP_EN enables the timestamp counter and evt_ts.
module sync_edge_event_queue
    import sync_evt_pkg::*;
#(
    parameter int   FILTER_CYCLES = 3,
    parameter int   DEPTH         = 4,
    parameter int   CNT_W         = 8,
    parameter logic INIT_LEVEL    = 1'b0,
    parameter int   TS_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_in,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic             evt_rise,
`ifdef SYNC_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0]  evt_ts,
`endif
    output logic             level,
    output logic             overflow,
    output logic [CNT_W-1:0] evt_count
);

    localparam int FW = cnt_w(FILTER_CYCLES + 1);
    localparam int EW = entry_w(TS_W);
    localparam logic [FW-1:0]    FC_V    = FW'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [FW-1:0] filt_cnt;
    logic [FW-1:0] cnt_inc;
    logic          mismatch;
    logic          hit;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;
    logic [EW-1:0] din;
    logic [EW-1:0] dout;

    assign mismatch  = (sync_in != level);
    assign cnt_inc   = filt_cnt + 1'b1;
    assign hit       = mismatch && (cnt_inc == FC_V);
    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign drop      = hit && full && !pop;
    assign evt_rise  = dout[0];

`ifdef SYNC_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ts_cnt <= '0;
        else
            ts_cnt <= ts_cnt + 1'b1;
    end

    assign din    = {ts_cnt, ~level};
    assign evt_ts = dout[EW-1:1];
`else
    assign din = ~level;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level    <= INIT_LEVEL;
            filt_cnt <= '0;
        end else if (!mismatch) begin
            filt_cnt <= '0;
        end else if (hit) begin
            level    <= ~level;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= cnt_inc;
        end
    end

    // clr wins over history but not over an edge seen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            evt_count <= '0;
        end else if (clr) begin
            overflow  <= drop;
            evt_count <= hit ? CNT_W'(1) : '0;
        end else begin
            overflow <= overflow | drop;
            if (hit && evt_count != CNT_MAX)
                evt_count <= evt_count + 1'b1;
        end
    end

    sync_evt_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hit),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sync_edge_event_queue.sv
// Directed table-driven bench for the edge event queue.
module tb_sync_edge_event_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_in;
    logic       clr;
    logic       evt_ready;
    logic       evt_valid;
    logic       evt_rise;
    logic       level;
    logic       overflow;
    logic [7:0] evt_count;
`ifdef SYNC_EVT_TIMESTAMP_EN
    logic [15:0] evt_ts;
    logic [15:0] evt_ts2;
`endif

    logic       sin2;
    logic       valid2;
    logic       rise2;
    logic       level2;
    logic       ovf2;
    logic [1:0] count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_edge_event_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_in   (sync_in),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_rise  (evt_rise),
`ifdef SYNC_EVT_TIMESTAMP_EN
        .evt_ts    (evt_ts),
`endif
        .level     (level),
        .overflow  (overflow),
        .evt_count (evt_count)
    );

    sync_edge_event_queue #(
        .FILTER_CYCLES (1),
        .CNT_W         (2)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_in   (sin2),
        .clr       (1'b0),
        .evt_ready (1'b1),
        .evt_valid (valid2),
        .evt_rise  (rise2),
`ifdef SYNC_EVT_TIMESTAMP_EN
        .evt_ts    (evt_ts2),
`endif
        .level     (level2),
        .overflow  (ovf2),
        .evt_count (count2)
    );

    typedef struct {
        logic sin;
        logic rdy;
        logic clr;
        logic lvl;
        logic val;
        logic rise;
        int   cnt;
        logic ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic c,
                       input logic l, input logic v, input logic ri,
                       input int n, input logic o);
        vec_t t;
        t.sin = s; t.rdy = r; t.clr = c;
        t.lvl = l; t.val = v; t.rise = ri; t.cnt = n; t.ovf = o;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic l, input logic v,
                           input logic ri, input int n, input logic o);
        chk({tag, " level"}, int'(level), int'(l));
        chk({tag, " evt_valid"}, int'(evt_valid), int'(v));
        chk({tag, " evt_rise"}, int'(evt_rise), int'(ri));
        chk({tag, " evt_count"}, int'(evt_count), n);
        chk({tag, " overflow"}, int'(overflow), int'(o));
    endtask

    task automatic hold(input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            sync_in = s;
            step();
        end
    endtask

    initial begin
        // filter reject
        add(1,0,0, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);
        // accept rise after 3 samples
        add(1,0,0, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        add(1,0,0, 1,1,1,1,0);
        // fill the FIFO: F, R, F
        add(0,0,0, 1,1,1,1,0);
        add(0,0,0, 1,1,1,1,0);
        add(0,0,0, 0,1,1,2,0);
        add(1,0,0, 0,1,1,2,0);
        add(1,0,0, 0,1,1,2,0);
        add(1,0,0, 1,1,1,3,0);
        add(0,0,0, 1,1,1,3,0);
        add(0,0,0, 1,1,1,3,0);
        add(0,0,0, 0,1,1,4,0);
        // two dropped events
        add(1,0,0, 0,1,1,4,0);
        add(1,0,0, 0,1,1,4,0);
        add(1,0,0, 1,1,1,5,1);
        add(0,0,0, 1,1,1,5,1);
        add(0,0,0, 1,1,1,5,1);
        add(0,0,0, 0,1,1,6,1);
        // clr without an edge
        add(0,0,1, 0,1,1,0,0);
        // full with simultaneous pop
        add(1,0,0, 0,1,1,0,0);
        add(1,0,0, 0,1,1,0,0);
        add(1,1,0, 1,1,0,1,0);
        // drop again, then pop one slot free
        add(0,0,0, 1,1,0,1,0);
        add(0,0,0, 1,1,0,1,0);
        add(0,0,0, 0,1,0,2,1);
        add(0,1,0, 0,1,1,2,1);
        // clr colliding with an accepted edge
        add(1,0,0, 0,1,1,2,1);
        add(1,0,0, 0,1,1,2,1);
        add(1,0,1, 1,1,1,1,0);
        // drain R, F, R, R
        add(1,1,0, 1,1,0,1,0);
        add(1,1,0, 1,1,1,1,0);
        add(1,1,0, 1,1,1,1,0);
        add(1,1,0, 1,0,0,1,0);
        // push into empty FIFO while ready: no bypass
        add(0,1,0, 1,0,0,1,0);
        add(0,1,0, 1,0,0,1,0);
        add(0,1,0, 0,1,0,2,0);
        add(0,1,0, 0,0,0,2,0);

        rst_n = 1'b0;
        sync_in = 1'b0;
        clr = 1'b0;
        evt_ready = 1'b0;
        sin2 = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            sync_in   = vecs[i].sin;
            evt_ready = vecs[i].rdy;
            clr       = vecs[i].clr;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].val,
                    vecs[i].rise, vecs[i].cnt, vecs[i].ovf);
        end

        // reset mid-operation: 3 queued, filter at 2
        clr = 1'b0;
        evt_ready = 1'b0;
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 3);
        hold(1'b0, 2);
        chk_all("pre_rst", 1, 1, 1, 5, 0);
        sync_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        hold(1'b1, 2);
        chk_all("post_rst_mis", 0, 0, 0, 0, 0);
        hold(1'b0, 3);
        chk_all("post_rst_idle", 0, 0, 0, 0, 0);

        // saturation: CNT_W=2, one edge per cycle
        for (int i = 1; i <= 5; i++) begin
            sin2 = ~sin2;
            step();
            chk($sformatf("sat_count%0d", i), int'(count2), (i < 3) ? i : 3);
            chk($sformatf("sat_level%0d", i), int'(level2), i % 2);
        end
        chk("sat_overflow", int'(ovf2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
